ps2_mouse_init: RTL and testbench

Power-up and recovery sequencer for the PS/2 mouse port. It drives the PS/2 transceiver's command channel (`cmd`/`dat`/`ready`) and watches its receive channel (`hit`/`kbd`). It runs a reset, defaults, rate, resolution and enable command sequence with per-byte acknowledge checking, timeouts and bounded retries. Once the sequence completes, it passes the received byte stream through to the mouse packet decoder. Status outputs tell the rest of the system whether the mouse is up.

---
 rtl/ps2_mouse_init_if.sv | 29 ++
 rtl/ps2_mouse_init.sv | 195 +++++++++++++++++++
 tb/tb_ps2_mouse_init.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_mouse_init_if.sv
// Command/receive/status bundle between the mouse init sequencer and its
// surroundings (PS/2 transceiver, packet decoder, system status).
interface ps2_mouse_init_if;
   logic       start;
   logic       cmd;
   logic [7:0] dat;
   logic       ready;
   logic       hit;
   logic [7:0] kbd;
   logic       busy;
   logic       done;
   logic       error;
   logic [2:0] err_step;
   logic [7:0] dev_id;
   logic       rx_valid;
   logic [7:0] rx_data;

   // Sequencer side
   modport master (
      input  start, ready, hit, kbd,
      output cmd, dat, busy, done, error, err_step, dev_id, rx_valid, rx_data
   );

   // Transceiver / system side
   modport slave (
      output start, ready, hit, kbd,
      input  cmd, dat, busy, done, error, err_step, dev_id, rx_valid, rx_data
   );
endinterface

// File: rtl/ps2_mouse_init.sv
// PS/2 mouse power-up sequencer: sends FF, F6, F3 RATE, E8 RES, F4 with
// ack checking, timeouts and bounded retries, then passes received bytes
// through to the packet decoder.
module ps2_mouse_init #(
   parameter logic [7:0]  RATE    = 8'h64,
   parameter logic [7:0]  RES     = 8'h02,
   parameter int unsigned T_ACK   = 625000,
   parameter int unsigned T_BAT   = 12500000,
   parameter int unsigned RETRIES = 3
) (
   input logic               clock,
   input logic               reset,
   ps2_mouse_init_if.master  bus
);

   localparam int unsigned RetryW   = (RETRIES < 1) ? 1 : $clog2(RETRIES + 1);
   localparam logic [RetryW-1:0] RetryMax = RetryW'(RETRIES);
   localparam logic [23:0]  AckLast  = 24'(T_ACK - 1);
   localparam logic [23:0]  BatLast  = 24'(T_BAT - 1);

   typedef enum logic [2:0] {
      StIdle, StSend, StWaitAck, StWaitBat, StWaitId, StDone, StFail
   } state_e;

   state_e            state_q, state_d;
   logic [2:0]        step_q, step_d;
   logic [RetryW-1:0] retry_q, retry_d;
   logic [23:0]       timer_q, timer_d;
   logic              cmd_q, cmd_d;
   logic [7:0]        dat_q, dat_d;
   logic [2:0]        err_step_q, err_step_d;
   logic [7:0]        dev_id_q, dev_id_d;
   logic              rx_valid_q, rx_valid_d;
   logic [7:0]        rx_data_q, rx_data_d;
   logic              fail_attempt;
   logic [2:0]        fail_step;

   function automatic logic [7:0] step_byte(input logic [2:0] idx);
      case (idx)
         3'd0:    return 8'hFF;
         3'd1:    return 8'hF6;
         3'd2:    return 8'hF3;
         3'd3:    return RATE;
         3'd4:    return 8'hE8;
         3'd5:    return RES;
         default: return 8'hF4;
      endcase
   endfunction

   // State and output registers, all cleared asynchronously
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q    <= StIdle;
         step_q     <= '0;
         retry_q    <= '0;
         timer_q    <= '0;
         cmd_q      <= 1'b0;
         dat_q      <= '0;
         err_step_q <= '0;
         dev_id_q   <= '0;
         rx_valid_q <= 1'b0;
         rx_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         step_q     <= step_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         cmd_q      <= cmd_d;
         dat_q      <= dat_d;
         err_step_q <= err_step_d;
         dev_id_q   <= dev_id_d;
         rx_valid_q <= rx_valid_d;
         rx_data_q  <= rx_data_d;
      end
   end

   // Next-state logic: sequencing, ack/timeout decisions and retry accounting
   always_comb begin
      state_d      = state_q;
      step_d       = step_q;
      retry_d      = retry_q;
      timer_d      = (timer_q == '1) ? timer_q : timer_q + 24'd1;
      cmd_d        = 1'b0;
      dat_d        = dat_q;
      err_step_d   = err_step_q;
      dev_id_d     = dev_id_q;
      rx_valid_d   = 1'b0;
      rx_data_d    = rx_data_q;
      fail_attempt = 1'b0;
      fail_step    = step_q;

      if (bus.start) begin
         // Restart wins over everything, including a same-cycle hit
         state_d    = StSend;
         step_d     = '0;
         retry_d    = '0;
         err_step_d = '0;
         timer_d    = '0;
      end else begin
         case (state_q)
            StIdle: begin
               state_d = StSend;
               step_d  = '0;
               retry_d = '0;
               timer_d = '0;
            end
            StSend: begin
               timer_d = '0;
               if (bus.ready) begin
                  cmd_d   = 1'b1;
                  dat_d   = step_byte(step_q);
                  state_d = StWaitAck;
               end
            end
            StWaitAck: begin
               if (bus.hit) begin
                  if (bus.kbd == 8'hFA) begin
                     if (step_q == 3'd0) begin
                        state_d = StWaitBat;
                        timer_d = '0;
                     end else if (step_q == 3'd6) begin
                        state_d = StDone;
                     end else begin
                        step_d  = step_q + 3'd1;
                        retry_d = '0;
                        state_d = StSend;
                     end
                  end else begin
                     fail_attempt = 1'b1;
                  end
               end else if (timer_q == AckLast) begin
                  fail_attempt = 1'b1;
               end
            end
            StWaitBat: begin
               fail_step = '0;
               if (bus.hit) begin
                  if (bus.kbd == 8'hAA) begin
                     state_d = StWaitId;
                     timer_d = '0;
                  end else begin
                     fail_attempt = 1'b1;
                  end
               end else if (timer_q == BatLast) begin
                  fail_attempt = 1'b1;
               end
            end
            StWaitId: begin
               fail_step = '0;
               if (bus.hit) begin
                  dev_id_d = bus.kbd;
                  step_d   = 3'd1;
                  retry_d  = '0;
                  state_d  = StSend;
               end else if (timer_q == AckLast) begin
                  fail_attempt = 1'b1;
               end
            end
            StDone: begin
               if (bus.hit) begin
                  rx_valid_d = 1'b1;
                  rx_data_d  = bus.kbd;
               end
            end
            StFail: ;
            default: state_d = StIdle;
         endcase

         // A failed attempt retries the same step until the budget runs out
         if (fail_attempt) begin
            step_d  = fail_step;
            timer_d = '0;
            if (retry_q < RetryMax) begin
               retry_d = retry_q + RetryW'(1);
               state_d = StSend;
            end else begin
               err_step_d = fail_step;
               state_d    = StFail;
            end
         end
      end
   end

   assign bus.cmd      = cmd_q;
   assign bus.dat      = dat_q;
   assign bus.busy     = (state_q == StSend) || (state_q == StWaitAck) ||
                         (state_q == StWaitBat) || (state_q == StWaitId);
   assign bus.done     = (state_q == StDone);
   assign bus.error    = (state_q == StFail);
   assign bus.err_step = err_step_q;
   assign bus.dev_id   = dev_id_q;
   assign bus.rx_valid = rx_valid_q;
   assign bus.rx_data  = rx_data_q;

endmodule

// File: tb/tb_ps2_mouse_init.sv
// Directed bench for ps2_mouse_init with a shortened ack timeout.
module tb_ps2_mouse_init;

   localparam int unsigned TAck = 100;
   localparam int unsigned TBat = 300;

   logic clock;
   logic reset;
   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   cmd_cyc = 0;
   int   waited  = 0;
   int   c0      = 0;

   ps2_mouse_init_if bus ();

   ps2_mouse_init #(
      .RATE    (8'h64),
      .RES     (8'h02),
      .T_ACK   (TAck),
      .T_BAT   (TBat),
      .RETRIES (3)
   ) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Waits (bounded) for the next cmd pulse and checks the byte it carries
   task automatic wait_cmd(input logic [7:0] exp, input string tag);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.cmd !== 1'b1 && n < 400);
      waited  = n;
      cmd_cyc = cyc;
      chk({tag, "_seen"}, {31'd0, bus.cmd}, 32'd1);
      chk({tag, "_dat"}, {24'd0, bus.dat}, {24'd0, exp});
   endtask

   task automatic send_byte(input logic [7:0] b);
      bus.hit = 1'b1;
      bus.kbd = b;
      tick();
      bus.hit = 1'b0;
   endtask

   task automatic answer(input logic [7:0] exp, input logic [7:0] resp, input string tag);
      wait_cmd(exp, tag);
      send_byte(resp);
      chk({tag, "_cmdw"}, {31'd0, bus.cmd}, 32'd0);
      chk({tag, "_norx"}, {31'd0, bus.rx_valid}, 32'd0);
   endtask

   task automatic pulse_start();
      bus.start = 1'b1;
      tick();
      bus.start = 1'b0;
   endtask

   initial begin
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.ready = 1'b1;
      bus.hit   = 1'b0;
      bus.kbd   = 8'h00;
      repeat (3) tick();

      // Reset values
      chk("rst_cmd", {31'd0, bus.cmd}, 32'd0);
      chk("rst_dat", {24'd0, bus.dat}, 32'd0);
      chk("rst_busy", {31'd0, bus.busy}, 32'd0);
      chk("rst_done", {31'd0, bus.done}, 32'd0);
      chk("rst_error", {31'd0, bus.error}, 32'd0);
      chk("rst_errstep", {29'd0, bus.err_step}, 32'd0);
      chk("rst_devid", {24'd0, bus.dev_id}, 32'd0);
      chk("rst_rxv", {31'd0, bus.rx_valid}, 32'd0);
      chk("rst_rxd", {24'd0, bus.rx_data}, 32'd0);

      // Happy path: IDLE then SEND, so first cmd two clocks after release
      reset = 1'b0;
      wait_cmd(8'hFF, "h0");
      chk("first_cmd_lat", waited, 32'd2);
      send_byte(8'hFA);
      chk("h0_cmdw", {31'd0, bus.cmd}, 32'd0);
      send_byte(8'hAA);
      send_byte(8'h00);
      chk("h_norx_id", {31'd0, bus.rx_valid}, 32'd0);
      answer(8'hF6, 8'hFA, "h1");
      answer(8'hF3, 8'hFA, "h2");
      answer(8'h64, 8'hFA, "h3");
      answer(8'hE8, 8'hFA, "h4");
      answer(8'h02, 8'hFA, "h5");
      answer(8'hF4, 8'hFA, "h6");
      chk("h_done", {31'd0, bus.done}, 32'd1);
      chk("h_busy", {31'd0, bus.busy}, 32'd0);
      chk("h_error", {31'd0, bus.error}, 32'd0);
      chk("h_devid", {24'd0, bus.dev_id}, 32'd0);

      // Pass-through: one clock from hit to rx_valid
      send_byte(8'h08);
      chk("pt08_v", {31'd0, bus.rx_valid}, 32'd1);
      chk("pt08_d", {24'd0, bus.rx_data}, 32'h08);
      tick();
      chk("pt08_off", {31'd0, bus.rx_valid}, 32'd0);
      send_byte(8'h05);
      chk("pt05_v", {31'd0, bus.rx_valid}, 32'd1);
      chk("pt05_d", {24'd0, bus.rx_data}, 32'h05);
      send_byte(8'hFB);
      chk("ptFB_v", {31'd0, bus.rx_valid}, 32'd1);
      chk("ptFB_d", {24'd0, bus.rx_data}, 32'hFB);
      tick();
      chk("ptFB_off", {31'd0, bus.rx_valid}, 32'd0);

      // start together with hit in DONE: start wins, byte dropped
      bus.start = 1'b1;
      bus.hit   = 1'b1;
      bus.kbd   = 8'h55;
      tick();
      bus.start = 1'b0;
      bus.hit   = 1'b0;
      chk("st_rxv", {31'd0, bus.rx_valid}, 32'd0);
      chk("st_done", {31'd0, bus.done}, 32'd0);
      chk("st_busy", {31'd0, bus.busy}, 32'd1);

      // Resend on FE once; hit at the terminal timer count wins over timeout
      answer(8'hFF, 8'hFA, "r0");
      send_byte(8'hAA);
      send_byte(8'h03);
      wait_cmd(8'hF6, "r1");
      repeat (TAck - 1) tick();
      send_byte(8'hFA);
      answer(8'hF3, 8'hFE, "r2a");
      answer(8'hF3, 8'hFA, "r2b");
      answer(8'h64, 8'hFA, "r3");
      answer(8'hE8, 8'hFA, "r4");
      answer(8'h02, 8'hFA, "r5");
      answer(8'hF4, 8'hFA, "r6");
      chk("r_done", {31'd0, bus.done}, 32'd1);
      chk("r_devid", {24'd0, bus.dev_id}, 32'h03);

      // FE four times on F3 exhausts the retries
      pulse_start();
      answer(8'hFF, 8'hFA, "f0");
      send_byte(8'hAA);
      send_byte(8'h00);
      answer(8'hF6, 8'hFA, "f1");
      answer(8'hF3, 8'hFE, "f2a");
      answer(8'hF3, 8'hFE, "f2b");
      answer(8'hF3, 8'hFE, "f2c");
      chk("f_busy3", {31'd0, bus.busy}, 32'd1);
      answer(8'hF3, 8'hFE, "f2d");
      chk("f_error", {31'd0, bus.error}, 32'd1);
      chk("f_errstep", {29'd0, bus.err_step}, 32'd2);
      chk("f_busy", {31'd0, bus.busy}, 32'd0);

      // Ack timeout on F6: retry after T_ACK wait cycles plus one SEND cycle
      pulse_start();
      chk("t_errclr", {31'd0, bus.error}, 32'd0);
      chk("t_stepclr", {29'd0, bus.err_step}, 32'd0);
      answer(8'hFF, 8'hFA, "t0");
      send_byte(8'hAA);
      send_byte(8'h00);
      wait_cmd(8'hF6, "t1a");
      for (int a = 0; a < 3; a++) begin
         c0 = cmd_cyc;
         wait_cmd(8'hF6, "t1r");
         chk("t_spacing", cmd_cyc - c0, TAck + 1);
      end
      repeat (TAck - 1) tick();
      chk("t_err_early", {31'd0, bus.error}, 32'd0);
      chk("t_busy_early", {31'd0, bus.busy}, 32'd1);
      tick();
      chk("t_error", {31'd0, bus.error}, 32'd1);
      chk("t_errstep", {29'd0, bus.err_step}, 32'd1);

      // Self-test failure: FC instead of AA resends FF until retries run out
      pulse_start();
      for (int a = 0; a < 3; a++) begin
         answer(8'hFF, 8'hFA, "b0");
         send_byte(8'hFC);
         chk("b_busy", {31'd0, bus.busy}, 32'd1);
      end
      answer(8'hFF, 8'hFA, "b0last");
      send_byte(8'hFC);
      chk("b_error", {31'd0, bus.error}, 32'd1);
      chk("b_errstep", {29'd0, bus.err_step}, 32'd0);

      // Asynchronous reset while waiting for an ack
      pulse_start();
      answer(8'hFF, 8'hFA, "a0");
      send_byte(8'hAA);
      send_byte(8'h5A);
      chk("a_devid", {24'd0, bus.dev_id}, 32'h5A);
      wait_cmd(8'hF6, "a1");
      reset = 1'b1;
      #1;
      chk("a_cmd", {31'd0, bus.cmd}, 32'd0);
      chk("a_dat", {24'd0, bus.dat}, 32'd0);
      chk("a_busy", {31'd0, bus.busy}, 32'd0);
      chk("a_devid0", {24'd0, bus.dev_id}, 32'd0);
      tick();
      reset     = 1'b0;
      bus.ready = 1'b0;
      repeat (5) tick();
      chk("a_hold_busy", {31'd0, bus.busy}, 32'd1);
      chk("a_hold_cmd", {31'd0, bus.cmd}, 32'd0);
      bus.ready = 1'b1;
      wait_cmd(8'hFF, "a_restart");
      tick();
      chk("a_cmdw", {31'd0, bus.cmd}, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
